ssd_decoder: RTL

- Receive-side counterpart of the 2-digit Pmod seven-segment display driver.
- Samples the multiplexed segment lines (a..g) and digit-select line, waits for each digit pattern to settle, and decodes each pattern back to a hex nibble.
- Reassembles the 8-bit value and presents it with a valid pulse.
- Used for on-board loopback self-test of the display path and as a bench monitor for display-driving logic.

---
 rtl/ssd_decoder_if.sv | 27 ++
 rtl/ssd_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ssd_decoder_if.sv
// rtl/ssd_decoder_if.sv - display-line inputs and decoded-frame outputs of the seven-segment decoder
interface ssd_decoder_if;
    logic [6:0] i_seg;
    logic       i_seg_sel;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_error;
    logic       o_timeout;

    modport master (
        output i_seg,
        output i_seg_sel,
        input  o_data,
        input  o_valid,
        input  o_error,
        input  o_timeout
    );

    modport slave (
        input  i_seg,
        input  i_seg_sel,
        output o_data,
        output o_valid,
        output o_error,
        output o_timeout
    );
endinterface

// File: rtl/ssd_decoder.sv
// rtl/ssd_decoder.sv - samples a 2-digit multiplexed seven-segment display and rebuilds the byte
module ssd_decoder #(
    parameter int STABLE_CYCLES   = 1024,
    parameter int TIMEOUT_CYCLES  = 2**22,
    parameter bit SEG_ACTIVE_HIGH = 1'b1,
    parameter bit SEL_LOW_IS_LSD  = 1'b1
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    ssd_decoder_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STB_SAT  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]    SEG_INV  = SEG_ACTIVE_HIGH ? 7'h00 : 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_ONE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    logic [7:0]    meta_vec;
    logic [7:0]    sync_vec;
    logic [7:0]    prev_vec;
    logic [SW-1:0] stable_cnt;
    logic          strobe;
    logic          stable_sel;
    logic [6:0]    stable_seg;
    logic [3:0]    dec_nibble;
    logic          dec_error;
    state_t        state;
    logic          held_sel;
    logic [3:0]    held_nibble;
    logic          held_error;
    logic [TW-1:0] tmo_cnt;

    // Two-flop synchronizer on {sel, segments}; raw polarity is kept so change detection is polarity-neutral
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_vec <= '0;
            sync_vec <= '0;
        end else begin
            meta_vec <= {bus.i_seg_sel, bus.i_seg};
            sync_vec <= meta_vec;
        end
    end

    // Count cycles the synchronized vector has stayed put; saturating one past the strobe point gives a single strobe
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev_vec   <= '0;
            stable_cnt <= '0;
        end else begin
            prev_vec <= sync_vec;
            if (sync_vec != prev_vec) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STB_SAT) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    // prev_vec holds the value that was stable throughout the counted run, so it is the one decoded
    assign strobe     = (stable_cnt == STB_LAST);
    assign stable_sel = prev_vec[7];
    assign stable_seg = prev_vec[6:0] ^ SEG_INV;

    // Segment pattern (gfedcba) to hex nibble; blanks and unknown shapes flag an error
    always_comb begin
        dec_nibble = 4'h0;
        dec_error  = 1'b0;
        case (stable_seg)
            7'h3F: dec_nibble = 4'h0;
            7'h06: dec_nibble = 4'h1;
            7'h5B: dec_nibble = 4'h2;
            7'h4F: dec_nibble = 4'h3;
            7'h66: dec_nibble = 4'h4;
            7'h6D: dec_nibble = 4'h5;
            7'h7D: dec_nibble = 4'h6;
            7'h07: dec_nibble = 4'h7;
            7'h7F: dec_nibble = 4'h8;
            7'h6F: dec_nibble = 4'h9;
            7'h77: dec_nibble = 4'hA;
            7'h7C: dec_nibble = 4'hB;
            7'h39: dec_nibble = 4'hC;
            7'h5E: dec_nibble = 4'hD;
            7'h79: dec_nibble = 4'hE;
            7'h71: dec_nibble = 4'hF;
            default: dec_error = 1'b1;
        endcase
    end

    // Frame assembly: hold one digit until a digit with the other select arrives, then emit both for one cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            held_sel    <= 1'b0;
            held_nibble <= 4'h0;
            held_error  <= 1'b0;
            bus.o_data  <= 8'h00;
            bus.o_valid <= 1'b0;
            bus.o_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.o_valid <= 1'b0;
                    if (strobe) begin
                        held_sel    <= stable_sel;
                        held_nibble <= dec_nibble;
                        held_error  <= dec_error;
                        state       <= GOT_ONE;
                    end
                end
                GOT_ONE: begin
                    bus.o_valid <= 1'b0;
                    if (strobe) begin
                        if (stable_sel == held_sel) begin
                            held_nibble <= dec_nibble;
                            held_error  <= dec_error;
                        end else begin
                            if (stable_sel == SEL_LOW_IS_LSD) begin
                                bus.o_data <= {dec_nibble, held_nibble};
                            end else begin
                                bus.o_data <= {held_nibble, dec_nibble};
                            end
                            bus.o_error <= held_error | dec_error;
                            bus.o_valid <= 1'b1;
                            state       <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    bus.o_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    bus.o_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Cycles since the last emitted frame, saturating at the timeout threshold
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt <= '0;
        end else if (state == EMIT) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.o_timeout = (tmo_cnt == TMO_LAST);
endmodule
